// File: rtl/uart_wb_bridge_pkg.sv
// Shared command/status codes and FSM state type for the UART-to-Wishbone bridge.
// Frame: CMD, ADDR_H, ADDR_L, then DATA_H, DATA_L for writes.
package uart_wb_bridge_pkg;

   localparam logic [7:0] CMD_READ   = 8'h00;
   localparam logic [7:0] CMD_WRITE  = 8'h01;

   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_BUS_ERR = 8'h01;
   localparam logic [7:0] ST_TIMEOUT = 8'h02;
   localparam logic [7:0] ST_BAD_CMD = 8'h03;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_H,
      S_ADDR_L,
      S_DATA_H,
      S_DATA_L,
      S_BUS,
      S_RESP_STATUS,
      S_RESP_DATA_H,
      S_RESP_DATA_L
   } state_t;

   function automatic logic is_rx_state(input state_t s);
      return s inside {S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L};
   endfunction

   function automatic logic is_resp_state(input state_t s);
      return s inside {S_RESP_STATUS, S_RESP_DATA_H, S_RESP_DATA_L};
   endfunction

endpackage

// File: rtl/uart_wb_bridge_if.sv
// Signal bundle between the bridge (master) and its UART receiver/transmitter and Wishbone slave.
// rx and tx are valid/ready streams: a byte moves on a clock edge where valid && ready are both high;
// the source holds data stable while valid is high and ready is low.
interface uart_wb_bridge_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        rx_overflow;
   logic        rx_frame_error;

   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [15:0] wb_addr;
   logic [15:0] wb_data_write;
   logic [15:0] wb_data_read;
   logic        wb_ack;
   logic        wb_err;

   modport master (
      input  rx_data, rx_valid, rx_overflow, rx_frame_error,
      output rx_ready,
      output tx_data, tx_valid,
      input  tx_ready,
      output wb_cyc, wb_stb, wb_we, wb_addr, wb_data_write,
      input  wb_data_read, wb_ack, wb_err
   );

   modport slave (
      output rx_data, rx_valid, rx_overflow, rx_frame_error,
      input  rx_ready,
      input  tx_data, tx_valid,
      output tx_ready,
      input  wb_cyc, wb_stb, wb_we, wb_addr, wb_data_write,
      output wb_data_read, wb_ack, wb_err
   );

endinterface

// File: rtl/uart_wb_bridge.sv
// Byte-stream command bridge: parses read/write frames from a UART receiver, runs one Wishbone
// classic cycle with a timeout, and streams a status byte (plus read data) back to the transmitter.
module uart_wb_bridge
   import uart_wb_bridge_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   uart_wb_bridge_if.master bus,
   output state_t           dbg_state
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic        we_q;
   logic        stb_q;
   logic [7:0]  tmo_cnt;
   logic [7:0]  status_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q;
   logic [7:0]  tx_data_q;

   logic       rx_open;
   logic       rx_abort;
   logic       rx_take;
   logic       tx_take;
   logic       cmd_ok;
   logic       bus_term;
   logic [7:0] term_status;

   assign rx_open  = is_rx_state(state);
   assign rx_abort = rx_open && (bus.rx_overflow || bus.rx_frame_error);
   // A byte arriving together with a receiver error belongs to the broken frame and is dropped.
   assign rx_take  = rx_open && bus.rx_valid && !rx_abort;
   assign tx_take  = is_resp_state(state) && bus.tx_ready;
   assign cmd_ok   = (bus.rx_data == CMD_READ) || (bus.rx_data == CMD_WRITE);
   assign bus_term = (state == S_BUS) && stb_q &&
                     (bus.wb_ack || bus.wb_err || (tmo_cnt == TMO_LAST));

   always_comb begin
      term_status = ST_TIMEOUT;
      if (bus.wb_err)
         term_status = ST_BUS_ERR;
      else if (bus.wb_ack)
         term_status = ST_OK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         we_q     <= 1'b0;
         stb_q    <= 1'b0;
         tmo_cnt  <= 8'd0;
         status_q <= ST_OK;
      end else if (rx_abort) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (rx_take) begin
               if (cmd_ok) begin
                  we_q  <= bus.rx_data[0];
                  state <= S_ADDR_H;
               end else begin
                  status_q <= ST_BAD_CMD;
                  state    <= S_RESP_STATUS;
               end
            end
            S_ADDR_H: if (rx_take) state <= S_ADDR_L;
            S_ADDR_L: if (rx_take) begin
               if (we_q) begin
                  state <= S_DATA_H;
               end else begin
                  state   <= S_BUS;
                  stb_q   <= 1'b1;
                  tmo_cnt <= 8'd0;
               end
            end
            S_DATA_H: if (rx_take) state <= S_DATA_L;
            S_DATA_L: if (rx_take) begin
               state   <= S_BUS;
               stb_q   <= 1'b1;
               tmo_cnt <= 8'd0;
            end
            S_BUS: begin
               if (stb_q) tmo_cnt <= tmo_cnt + 8'd1;
               if (bus_term) begin
                  stb_q    <= 1'b0;
                  status_q <= term_status;
                  state    <= S_RESP_STATUS;
               end
            end
            S_RESP_STATUS: if (tx_take)
               state <= (status_q == ST_OK && !we_q) ? S_RESP_DATA_H : S_IDLE;
            S_RESP_DATA_H: if (tx_take) state <= S_RESP_DATA_L;
            S_RESP_DATA_L: if (tx_take) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Datapath registers carry no reset; they are always loaded before being presented.
   always_ff @(posedge clk) begin
      case (state)
         S_IDLE:   if (rx_take && !cmd_ok) tx_data_q <= ST_BAD_CMD;
         S_ADDR_H: if (rx_take) addr_q[15:8]  <= bus.rx_data;
         S_ADDR_L: if (rx_take) addr_q[7:0]   <= bus.rx_data;
         S_DATA_H: if (rx_take) wdata_q[15:8] <= bus.rx_data;
         S_DATA_L: if (rx_take) wdata_q[7:0]  <= bus.rx_data;
         S_BUS: if (bus_term) begin
            tx_data_q <= term_status;
            if (term_status == ST_OK && !we_q) rdata_q <= bus.wb_data_read;
         end
         S_RESP_STATUS: if (tx_take) tx_data_q <= rdata_q[15:8];
         S_RESP_DATA_H: if (tx_take) tx_data_q <= rdata_q[7:0];
         default: ;
      endcase
   end

   assign bus.rx_ready      = rx_open;
   assign bus.tx_valid      = is_resp_state(state);
   assign bus.tx_data       = tx_data_q;
   assign bus.wb_cyc        = stb_q;
   assign bus.wb_stb        = stb_q;
   assign bus.wb_we         = we_q;
   assign bus.wb_addr       = addr_q;
   assign bus.wb_data_write = wdata_q;
   assign dbg_state         = state;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Self-checking bench for uart_wb_bridge: directed frames plus randomized commands, slave behaviour
// and transmitter back-pressure, checked against a frame-level reference model.
module tb_uart_wb_bridge;
   import uart_wb_bridge_pkg::*;

   localparam int TMO      = 4;
   localparam int M_ACK    = 0;
   localparam int M_ERR    = 1;
   localparam int M_BOTH   = 2;
   localparam int M_SILENT = 3;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t dbg_state;

   uart_wb_bridge_if bus();

   uart_wb_bridge #(.TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   logic [15:0] mon_addr_q[$];
   logic [15:0] mon_wdata_q[$];
   logic        mon_we_q[$];
   int          mon_len_q[$];

   int          stb_len = 0;
   logic [15:0] cur_addr;
   logic [15:0] cur_wdata;
   logic        cur_we;
   int          cyc_stb_err = 0;
   int          bus_stab_err = 0;
   int          tx_stab_err = 0;
   int          tx_valid_cycles = 0;

   int          slv_mode = M_ACK;
   int          slv_delay = 0;
   logic [15:0] slv_rdata = 16'h0;
   logic        ovf_in_bus = 1'b0;
   logic        ovf_pulse = 1'b0;
   logic        fe = 1'b0;

   int          stall_byte = -1;
   int          stall_left = 0;
   int          tx_count = 0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_tx = 8'h0;

   assign bus.rx_overflow    = ovf_pulse;
   assign bus.rx_frame_error = fe;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- Wishbone slave + bus monitor ----------------
   initial forever begin
      @(negedge clk);
      if (bus.wb_cyc !== bus.wb_stb) cyc_stb_err++;
      bus.wb_ack       = 1'b0;
      bus.wb_err       = 1'b0;
      bus.wb_data_read = 16'($urandom);
      ovf_pulse        = 1'b0;
      if (bus.wb_stb === 1'b1) begin
         if (stb_len == 0) begin
            cur_addr  = bus.wb_addr;
            cur_we    = bus.wb_we;
            cur_wdata = bus.wb_data_write;
            mon_addr_q.push_back(cur_addr);
            mon_we_q.push_back(cur_we);
            mon_wdata_q.push_back(cur_wdata);
            if (ovf_in_bus) ovf_pulse = 1'b1;
         end else if (bus.wb_addr !== cur_addr || bus.wb_we !== cur_we ||
                      bus.wb_data_write !== cur_wdata) begin
            bus_stab_err++;
         end
         stb_len++;
         if (stb_len == slv_delay + 1) begin
            case (slv_mode)
               M_ACK:  begin bus.wb_ack = 1'b1; bus.wb_data_read = slv_rdata; end
               M_ERR:  bus.wb_err = 1'b1;
               M_BOTH: begin bus.wb_ack = 1'b1; bus.wb_err = 1'b1; end
               default: ;
            endcase
         end
      end else if (stb_len != 0) begin
         mon_len_q.push_back(stb_len);
         stb_len = 0;
      end
   end

   // ---------------- transmitter sink ----------------
   initial forever begin
      @(negedge clk);
      if (bus.tx_valid === 1'b1) tx_valid_cycles++;
      if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_tx)) tx_stab_err++;
      if (bus.tx_valid === 1'b1 && tx_count == stall_byte && stall_left > 0) begin
         bus.tx_ready = 1'b0;
         stall_left--;
      end else begin
         bus.tx_ready = ($urandom_range(0, 3) != 0);
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready) begin
         got_q.push_back(bus.tx_data);
         tx_count++;
      end
      prev_stall = (bus.tx_valid === 1'b1) && !bus.tx_ready;
      prev_tx    = bus.tx_data;
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (bus.rx_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("rx_ready_wait", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic pulse_fe();
      @(negedge clk);
      fe = 1'b1;
      @(negedge clk);
      fe = 1'b0;
   endtask

   task automatic clear_sb();
      got_q.delete();
      exp_q.delete();
      mon_addr_q.delete();
      mon_we_q.delete();
      mon_wdata_q.delete();
      mon_len_q.delete();
      tx_count     = 0;
      bus_stab_err = 0;
      tx_stab_err  = 0;
   endtask

   // Sends one full frame and checks response bytes and bus activity against the reference model.
   task automatic run_cmd(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] wdata,
                          input int mode, input int delay, input logic [15:0] rdata,
                          input int stall_idx, input logic ovf);
      logic [7:0] st;
      logic       valid_cmd;
      int         n = 0;
      clear_sb();
      stall_byte = stall_idx;
      stall_left = (stall_idx >= 0) ? 5 : 0;
      slv_mode   = mode;
      slv_delay  = delay;
      slv_rdata  = rdata;
      ovf_in_bus = ovf;
      valid_cmd  = (cmd == 8'h00) || (cmd == 8'h01);

      if (!valid_cmd) begin
         exp_q.push_back(8'h03);
      end else begin
         st = (mode == M_SILENT) ? 8'h02 : (mode == M_ACK) ? 8'h00 : 8'h01;
         exp_q.push_back(st);
         if (cmd == 8'h00 && st == 8'h00) begin
            exp_q.push_back(rdata[15:8]);
            exp_q.push_back(rdata[7:0]);
         end
      end

      send_byte(cmd);
      if (valid_cmd) begin
         send_byte(addr[15:8]);
         send_byte(addr[7:0]);
         if (cmd == 8'h01) begin
            send_byte(wdata[15:8]);
            send_byte(wdata[7:0]);
         end
      end
      while (got_q.size() < exp_q.size() && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      ovf_in_bus = 1'b0;

      check("tx_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("tx_byte%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxxxxxx,
               32'(exp_q[i]));
      check("tx_stable", 32'(tx_stab_err), 32'd0);
      if (stall_idx >= 0) check("tx_stall_done", 32'(stall_left), 32'd0);
      if (valid_cmd) begin
         check("bus_cycles", 32'(mon_addr_q.size()), 32'd1);
         if (mon_addr_q.size() >= 1 && mon_len_q.size() >= 1) begin
            check("bus_addr", 32'(mon_addr_q[0]), 32'(addr));
            check("bus_we", 32'(mon_we_q[0]), 32'(cmd[0]));
            if (cmd == 8'h01) check("bus_wdata", 32'(mon_wdata_q[0]), 32'(wdata));
            check("stb_len", 32'(mon_len_q[0]), (mode == M_SILENT) ? 32'(TMO) : 32'(delay + 1));
         end
      end else begin
         check("bus_cycles", 32'(mon_addr_q.size()), 32'd0);
      end
      check("bus_stable", 32'(bus_stab_err), 32'd0);
   endtask

   // Sends the first k bytes of a write frame, then a frame error; nothing may come out.
   task automatic run_abort(input int k);
      logic [7:0] frame[5];
      frame[0] = 8'h01;
      for (int i = 1; i < 5; i++) frame[i] = 8'($urandom);
      clear_sb();
      slv_mode = M_ACK;
      for (int i = 0; i < k; i++) send_byte(frame[i]);
      pulse_fe();
      repeat (15) @(negedge clk);
      check("abort_no_tx", 32'(got_q.size()), 32'd0);
      check("abort_no_bus", 32'(mon_addr_q.size()), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int v0;
      int n;
      int r;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_cyc", 32'(bus.wb_cyc), 32'd0);
      check("rst_stb", 32'(bus.wb_stb), 32'd0);
      check("rst_we", 32'(bus.wb_we), 32'd0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));
      rst = 1'b0;
      @(negedge clk);
      check("idle_rx_ready", 32'(bus.rx_ready), 32'd1);

      run_cmd(8'h01, 16'h1234, 16'hABCD, M_ACK, 2, 16'h0000, -1, 1'b0);
      run_cmd(8'h00, 16'h0010, 16'h0000, M_ACK, 1, 16'hBEEF, 1, 1'b0);
      run_cmd(8'h00, 16'h0020, 16'h0000, M_SILENT, 0, 16'h0000, -1, 1'b0);
      run_cmd(8'h01, 16'h5555, 16'h1111, M_BOTH, 0, 16'h0000, -1, 1'b0);
      run_cmd(8'h7F, 16'h0000, 16'h0000, M_ACK, 0, 16'h0000, -1, 1'b0);

      // partial write killed by a frame error, then a clean read
      clear_sb();
      send_byte(8'h01);
      send_byte(8'h12);
      pulse_fe();
      run_cmd(8'h00, 16'h0030, 16'h0000, M_ACK, 0, 16'h0001, -1, 1'b0);

      // a byte accepted in the same cycle as a frame error is discarded
      @(negedge clk);
      bus.rx_data  = 8'h01;
      bus.rx_valid = 1'b1;
      fe           = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      fe           = 1'b0;
      run_cmd(8'h00, 16'h0044, 16'h0000, M_ACK, 0, 16'h4321, -1, 1'b0);

      // receiver overflow during the bus phase has no effect
      run_cmd(8'h00, 16'h00A5, 16'h0000, M_ACK, 3, 16'h1234, -1, 1'b1);

      // reset while the strobe is high
      clear_sb();
      slv_mode = M_SILENT;
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h40);
      n = 0;
      while (bus.wb_stb !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_stb_seen", 32'(bus.wb_stb), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_cyc_drop", 32'(bus.wb_cyc), 32'd0);
      check("rst_stb_drop", 32'(bus.wb_stb), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      v0 = tx_valid_cycles;
      repeat (20) @(negedge clk);
      check("rst_no_tx", 32'(tx_valid_cycles - v0), 32'd0);
      check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
      run_cmd(8'h01, 16'hC0DE, 16'h5A5A, M_ACK, 0, 16'h0000, -1, 1'b0);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, 9);
         if (r == 0)
            run_abort($urandom_range(1, 4));
         else if (r == 1)
            run_cmd(8'($urandom_range(2, 255)), 16'($urandom), 16'($urandom), M_ACK, 0,
                    16'($urandom), -1, 1'b0);
         else
            run_cmd(8'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 3), 16'($urandom), -1, 1'b0);
      end

      check("cyc_eq_stb", 32'(cyc_stb_err), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
